ppa_pipe_adder: RTL

//  Parametrised, pipelined parallel-prefix (Kogge-Stone) adder. Generalises the 16-bit PPA to any WIDTH.

---
 rtl/ppa_pipe_adder_if.sv | 37 +++
 rtl/ppa_pipe_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ppa_pipe_adder_if.sv
// Operand/result handshake bundle for ppa_pipe_adder.
// With PPA_OVF_EN defined, the bundle also carries the signed-overflow flag.
interface ppa_pipe_adder_if #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [TAG_W-1:0] out_tag;
`ifdef PPA_OVF_EN
   logic             ovf;
`endif

   modport slave (
      input  in_valid, a, b, cin, in_tag, out_ready,
`ifdef PPA_OVF_EN
      output ovf,
`endif
      output in_ready, out_valid, sum, cout, out_tag
   );

   modport master (
      output in_valid, a, b, cin, in_tag, out_ready,
`ifdef PPA_OVF_EN
      input  ovf,
`endif
      input  in_ready, out_valid, sum, cout, out_tag
   );
endinterface

// File: rtl/ppa_pipe_adder.sv
// Pipelined Kogge-Stone adder with valid/ready handshake and sideband tag.
// Latency is STAGES cycles; the whole pipe stalls together when the sink
// holds off. The optional overflow output is enabled by defining PPA_OVF_EN.
module ppa_pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input logic clk,
   input logic rst,
   ppa_pipe_adder_if.slave bus
);
   localparam int unsigned W      = WIDTH;
   localparam int unsigned NST    = STAGES;
   localparam int unsigned LEVELS = $clog2(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
   } gp_t;

   typedef struct packed {
      gp_t              gp;
      logic [WIDTH-1:0] p0;
      logic             cin;
`ifdef PPA_OVF_EN
      logic             amsb;
`endif
      logic [TAG_W-1:0] tag;
   } pre_t;

   // Prefix level reached at pipeline boundary i (ceil(i*LEVELS/STAGES)).
   function automatic int unsigned lvl(input int unsigned i);
      return (i * LEVELS + NST - 1) / NST;
   endfunction

   localparam int unsigned LAST_LVL = lvl(NST - 1);

   // Applies Kogge-Stone levels lo+1..hi to a (g,p) vector.
   function automatic gp_t kstep(input gp_t x, input int unsigned lo, input int unsigned hi);
      gp_t         y;
      gp_t         t;
      int unsigned d;
      y = x;
      for (int unsigned l = 1; l <= LEVELS; l++) begin
         if (l > lo && l <= hi) begin
            d = 32'd1 << (l - 1);
            t = y;
            for (int unsigned j = 0; j < W; j++) begin
               if (j >= d) begin
                  t.g[j] = y.g[j] | (y.p[j] & y.g[j-d]);
                  t.p[j] = y.p[j] & y.p[j-d];
               end
            end
            y = t;
         end
      end
      return y;
   endfunction

   function automatic logic [WIDTH-1:0] kgen(input gp_t x, input int unsigned lo, input int unsigned hi);
      gp_t y;
      y = kstep(x, lo, hi);
      return y.g;
   endfunction

   logic             advance;
   logic [NST-1:0]   vld;
   pre_t             fr;
   pre_t             last;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_n;
   logic             cout_n;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic [TAG_W-1:0] tag_r;

   assign advance       = !(vld[NST-1] && !bus.out_ready);
   assign bus.in_ready  = advance;
   assign bus.out_valid = vld[NST-1];
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;
   assign bus.out_tag   = tag_r;

   // Bit generate/propagate; cin is folded into bit 0 as a generate so the
   // prefix tree yields carries straight out of the group [j:0].
   always_comb begin
      fr         = '0;
      fr.gp.g    = bus.a & bus.b;
      fr.gp.p    = bus.a ^ bus.b;
      fr.gp.g[0] = fr.gp.g[0] | (fr.gp.p[0] & bus.cin);
      fr.p0      = bus.a ^ bus.b;
      fr.cin     = bus.cin;
`ifdef PPA_OVF_EN
      fr.amsb    = bus.a[W-1];
`endif
      fr.tag     = bus.in_tag;
   end

   // Valid bits shift with the data, bubbles included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else if (advance) begin
         vld[0] <= bus.in_valid;
         for (int unsigned k = 1; k < NST; k++) vld[k] <= vld[k-1];
      end
   end

   if (STAGES > 1) begin : g_pipe
      pre_t pr   [STAGES-1];
      pre_t pr_n [STAGES-1];

      // Next contents of each prefix register: advance the tree to its boundary.
      always_comb begin
         pr_n       = pr;
         pr_n[0]    = fr;
         pr_n[0].gp = kstep(fr.gp, 0, lvl(1));
         for (int unsigned k = 1; k < NST - 1; k++) begin
            pr_n[k]    = pr[k-1];
            pr_n[k].gp = kstep(pr[k-1].gp, lvl(k), lvl(k + 1));
         end
      end

      // Prefix pipeline registers, held as a whole on stall.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int unsigned k = 0; k < NST - 1; k++) pr[k] <= '0;
         end else if (advance) begin
            pr <= pr_n;
         end
      end

      assign last = pr[STAGES-2];
   end else begin : g_flat
      assign last = fr;
   end

   // Remaining prefix levels, sum XOR and carry out.
   always_comb begin
      carry  = kgen(last.gp, LAST_LVL, LEVELS);
      sum_n  = last.p0 ^ {carry[W-2:0], last.cin};
      cout_n = carry[W-1];
   end

   // Result registers drive the outputs directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r  <= '0;
         cout_r <= 1'b0;
         tag_r  <= '0;
      end else if (advance) begin
         sum_r  <= sum_n;
         cout_r <= cout_n;
         tag_r  <= last.tag;
      end
   end

`ifdef PPA_OVF_EN
   logic ovf_r;
   assign bus.ovf = ovf_r;

   // Equal operand signs (p0 msb clear) and a sum sign differing from them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (advance) begin
         ovf_r <= !last.p0[W-1] && (carry[W-2] != last.amsb);
      end
   end
`endif
endmodule
